frame_slot_scheduler: RTL and testbench

Allocates the four SDRAM frame slots between the CMOS writer, the VGA reader and the SD-card photo-save reader. The writer never overwrites a frame being displayed, the newest complete frame, or a frame locked for saving. The block sits between sys_ctrl and frame_read_write in the ext_mem_clk domain. It produces the slot indices and base addresses that drive the read_addr/write_addr selection.

---
 rtl/frame_slot_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_frame_slot_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_slot_scheduler
// Purpose  : Shares the four SDRAM frame slots among the CMOS writer, the
//            VGA reader and the SD-card photo-save reader. The writer never
//            lands on the slot being displayed, the newest complete frame,
//            or the frame locked for saving.
// Ports    : clk, rst                 - memory-domain clock, async reset
//            wr_frame_req/done/ack    - writer slot request / completion
//            rd_frame_req/ack         - reader switches to newest frame
//            save_req/done/ack/err    - lock / release newest frame for save
//            save_locked, frame_valid - status flags
//            write/read/save_index    - slot numbers (0..3)
//            write/read/save_base     - slot base addresses
//            drop_cnt                 - frames replaced before being shown
// Revision : 1.0 - initial release
// ============================================================================
module frame_slot_scheduler #(
  parameter int                    ADDR_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 24'd1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_frame_req,
  input  logic                  wr_frame_done,
  output logic                  wr_frame_ack,
  input  logic                  rd_frame_req,
  output logic                  rd_frame_ack,
  input  logic                  save_req,
  input  logic                  save_done,
  output logic                  save_ack,
  output logic                  save_err,
  output logic                  save_locked,
  output logic                  frame_valid,
  output logic [1:0]            write_index,
  output logic [1:0]            read_index,
  output logic [1:0]            save_index,
  output logic [ADDR_WIDTH-1:0] write_base,
  output logic [ADDR_WIDTH-1:0] read_base,
  output logic [ADDR_WIDTH-1:0] save_base,
  output logic [7:0]            drop_cnt
);

  // Sticky request flags; a repeated pulse merges into an already-set flag.
  logic       r_pend_done;
  logic       r_pend_sdone;
  logic       r_pend_sreq;
  logic       r_pend_rd;
  logic       r_pend_wr;

  // Newest complete frame and whether the reader has picked it up yet.
  logic [1:0] r_latest_idx;
  logic       r_latest_valid;
  logic       r_latest_read;
  logic       r_rd_active;

  logic       w_svc_done;
  logic       w_svc_sdone;
  logic       w_svc_sreq;
  logic       w_svc_rd;
  logic       w_svc_wr;
  logic [1:0] w_wr_sel;

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] idx);
    base_of = ADDR_WIDTH'(idx) * FRAME_STRIDE;
  endfunction

  function automatic logic slot_excluded(
    input logic [1:0] cand,
    input logic [1:0] ri, input logic ra,
    input logic [1:0] li, input logic lv,
    input logic [1:0] si, input logic sl
  );
    slot_excluded = (ra && cand == ri) || (lv && cand == li) || (sl && cand == si);
  endfunction

  // Fixed-priority single service per cycle.
  assign w_svc_done  = r_pend_done;
  assign w_svc_sdone = r_pend_sdone & ~r_pend_done;
  assign w_svc_sreq  = r_pend_sreq  & ~r_pend_done & ~r_pend_sdone;
  assign w_svc_rd    = r_pend_rd    & ~r_pend_done & ~r_pend_sdone & ~r_pend_sreq;
  assign w_svc_wr    = r_pend_wr    & ~r_pend_done & ~r_pend_sdone & ~r_pend_sreq
                                    & ~r_pend_rd;

  // Next write slot: first of w+1, w+2, w+3, w not held by someone else.
  // At most three slots can be held, so the search always succeeds.
  always_comb begin
    logic found;
    logic [1:0] cand;
    w_wr_sel = write_index;
    found    = 1'b0;
    cand     = write_index;
    for (int k = 1; k <= 4; k++) begin
      cand = write_index + 2'(k);
      if (!found && !slot_excluded(cand, read_index, r_rd_active,
                                   r_latest_idx, r_latest_valid,
                                   save_index, save_locked)) begin
        w_wr_sel = cand;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_done    <= 1'b0;
      r_pend_sdone   <= 1'b0;
      r_pend_sreq    <= 1'b0;
      r_pend_rd      <= 1'b0;
      r_pend_wr      <= 1'b0;
      r_latest_idx   <= 2'd0;
      r_latest_valid <= 1'b0;
      r_latest_read  <= 1'b0;
      r_rd_active    <= 1'b0;
      wr_frame_ack   <= 1'b0;
      rd_frame_ack   <= 1'b0;
      save_ack       <= 1'b0;
      save_err       <= 1'b0;
      save_locked    <= 1'b0;
      frame_valid    <= 1'b0;
      write_index    <= 2'd0;
      read_index     <= 2'd0;
      save_index     <= 2'd0;
      write_base     <= '0;
      read_base      <= '0;
      save_base      <= '0;
      drop_cnt       <= 8'd0;
    end else begin
      // A flag cleared by service this cycle is re-armed by a fresh pulse.
      r_pend_done  <= (r_pend_done  & ~w_svc_done)  | wr_frame_done;
      r_pend_sdone <= (r_pend_sdone & ~w_svc_sdone) | save_done;
      r_pend_sreq  <= (r_pend_sreq  & ~w_svc_sreq)  | save_req;
      r_pend_rd    <= (r_pend_rd    & ~w_svc_rd)    | rd_frame_req;
      r_pend_wr    <= (r_pend_wr    & ~w_svc_wr)    | wr_frame_req;

      wr_frame_ack <= 1'b0;
      rd_frame_ack <= 1'b0;
      save_ack     <= 1'b0;
      save_err     <= 1'b0;

      if (w_svc_done) begin
        // A complete frame never shown to the reader is being superseded.
        if (r_latest_valid && !r_latest_read && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
        r_latest_idx   <= write_index;
        r_latest_valid <= 1'b1;
        r_latest_read  <= 1'b0;
        frame_valid    <= 1'b1;
      end

      if (w_svc_sdone)
        save_locked <= 1'b0;

      if (w_svc_sreq) begin
        save_ack <= 1'b1;
        if (r_latest_valid && !save_locked) begin
          save_index  <= r_latest_idx;
          save_base   <= base_of(r_latest_idx);
          save_locked <= 1'b1;
        end else begin
          save_err <= 1'b1;
        end
      end

      if (w_svc_rd) begin
        rd_frame_ack <= 1'b1;
        if (r_latest_valid) begin
          read_index    <= r_latest_idx;
          read_base     <= base_of(r_latest_idx);
          r_rd_active   <= 1'b1;
          r_latest_read <= 1'b1;
        end
      end

      if (w_svc_wr) begin
        wr_frame_ack <= 1'b1;
        write_index  <= w_wr_sel;
        write_base   <= base_of(w_wr_sel);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_slot_scheduler
// Purpose  : Directed, table-driven self-checking bench for
//            frame_slot_scheduler plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_slot_scheduler;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_frame_req, wr_frame_done, rd_frame_req, save_req, save_done;
  logic          wr_frame_ack, rd_frame_ack, save_ack, save_err, save_locked, frame_valid;
  logic [1:0]    write_index, read_index, save_index;
  logic [AW-1:0] write_base, read_base, save_base;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  frame_slot_scheduler #(.ADDR_WIDTH(AW), .FRAME_STRIDE(24'd1048576)) dut (
    .clk(clk), .rst(rst),
    .wr_frame_req(wr_frame_req), .wr_frame_done(wr_frame_done), .wr_frame_ack(wr_frame_ack),
    .rd_frame_req(rd_frame_req), .rd_frame_ack(rd_frame_ack),
    .save_req(save_req), .save_done(save_done), .save_ack(save_ack), .save_err(save_err),
    .save_locked(save_locked), .frame_valid(frame_valid),
    .write_index(write_index), .read_index(read_index), .save_index(save_index),
    .write_base(write_base), .read_base(read_base), .save_base(save_base),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // pulses = {done, save_done, save_req, rd_req, wr_req}; acks = {wr, rd, save}
  typedef struct {
    logic [4:0] pulses;
    logic [2:0] acks;
    logic       err;
    logic       locked;
    logic       fv;
    logic [1:0] wi;
    logic [1:0] ri;
    logic [1:0] si;
    logic [7:0] drop;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [4:0] p, logic [2:0] a, logic e, logic lk, logic fv,
                              logic [1:0] wi, logic [1:0] ri, logic [1:0] si, logic [7:0] d);
    vec_t v;
    v.pulses = p; v.acks = a; v.err = e; v.locked = lk; v.fv = fv;
    v.wi = wi; v.ri = ri; v.si = si; v.drop = d;
    return v;
  endfunction

  function automatic logic [31:0] exp_base(logic [1:0] idx);
    return {8'd0, 2'b00, idx, 20'h0};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] p);
    {wr_frame_done, save_done, save_req, rd_frame_req, wr_frame_req} = p;
  endtask

  // Pulse for one rising edge; returns at the negedge after that edge (+1).
  task automatic pulse(logic [4:0] p);
    @(negedge clk);
    drive(p);
    @(negedge clk);
    drive(5'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " acks"}, {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);
    chk({tag, " err/lock/fv"}, {29'd0, save_err, save_locked, frame_valid}, 32'd0);
    chk({tag, " indices"}, {26'd0, write_index, read_index, save_index}, 32'd0);
    chk({tag, " wbase"}, {8'd0, write_base}, 32'd0);
    chk({tag, " rbase"}, {8'd0, read_base}, 32'd0);
    chk({tag, " sbase"}, {8'd0, save_base}, 32'd0);
    chk({tag, " drop"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               pulses    acks    err lk fv wi ri si drop
    tbl[0]  = mk(5'b00100, 3'b001, 1, 0, 0, 0, 0, 0, 0); // save with no frame
    tbl[1]  = mk(5'b00010, 3'b010, 0, 0, 0, 0, 0, 0, 0); // rd with no frame
    tbl[2]  = mk(5'b00001, 3'b100, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(5'b10000, 3'b000, 0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(5'b00010, 3'b010, 0, 0, 1, 1, 1, 0, 0);
    tbl[5]  = mk(5'b00001, 3'b100, 0, 0, 1, 2, 1, 0, 0);
    tbl[6]  = mk(5'b10000, 3'b000, 0, 0, 1, 2, 1, 0, 0);
    tbl[7]  = mk(5'b00001, 3'b100, 0, 0, 1, 3, 1, 0, 0);
    tbl[8]  = mk(5'b00100, 3'b001, 0, 1, 1, 3, 1, 2, 0);
    tbl[9]  = mk(5'b10000, 3'b000, 0, 1, 1, 3, 1, 2, 1); // unread frame dropped
    tbl[10] = mk(5'b00001, 3'b100, 0, 1, 1, 0, 1, 2, 1); // 1,2,3 held -> 0
    tbl[11] = mk(5'b00100, 3'b001, 1, 1, 1, 0, 1, 2, 1); // already locked
    tbl[12] = mk(5'b01000, 3'b000, 0, 0, 1, 0, 1, 2, 1);
    tbl[13] = mk(5'b01000, 3'b000, 0, 0, 1, 0, 1, 2, 1); // release when unlocked
    tbl[14] = mk(5'b00100, 3'b001, 0, 1, 1, 0, 1, 3, 1);
    tbl[15] = mk(5'b00010, 3'b010, 0, 1, 1, 0, 3, 3, 1);
    tbl[16] = mk(5'b10000, 3'b000, 0, 1, 1, 0, 3, 3, 1);
    tbl[17] = mk(5'b00001, 3'b100, 0, 1, 1, 1, 3, 3, 1);
    tbl[18] = mk(5'b10000, 3'b000, 0, 1, 1, 1, 3, 3, 2);
    tbl[19] = mk(5'b00001, 3'b100, 0, 1, 1, 2, 3, 3, 2);
    tbl[20] = mk(5'b00001, 3'b100, 0, 1, 1, 0, 3, 3, 2); // abort frame in slot 2
    tbl[21] = mk(5'b00001, 3'b100, 0, 1, 1, 2, 3, 3, 2); // aborted slot reused

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      pulse(tbl[i].pulses);
      chk({t, " acks@+1"}, {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);
      @(negedge clk);
      chk({t, " acks@+2"}, {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, {29'd0, tbl[i].acks});
      chk({t, " save_err"}, {31'd0, save_err}, {31'd0, tbl[i].err});
      chk({t, " save_locked"}, {31'd0, save_locked}, {31'd0, tbl[i].locked});
      chk({t, " frame_valid"}, {31'd0, frame_valid}, {31'd0, tbl[i].fv});
      chk({t, " write_index"}, {30'd0, write_index}, {30'd0, tbl[i].wi});
      chk({t, " read_index"}, {30'd0, read_index}, {30'd0, tbl[i].ri});
      chk({t, " save_index"}, {30'd0, save_index}, {30'd0, tbl[i].si});
      chk({t, " write_base"}, {8'd0, write_base}, exp_base(tbl[i].wi));
      chk({t, " read_base"}, {8'd0, read_base}, exp_base(tbl[i].ri));
      chk({t, " save_base"}, {8'd0, save_base}, exp_base(tbl[i].si));
      chk({t, " drop_cnt"}, {24'd0, drop_cnt}, {24'd0, tbl[i].drop});
    end

    // Async reset with rd+wr pending: outputs clear at once, nothing acked later.
    pulse(5'b00011);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst c%0d acks", c),
          {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);
    end
    chk("post_rst write_index", {30'd0, write_index}, 32'd0);

    // Simultaneous done, save_req, rd_req, wr_req.
    do_reset();
    pulse(5'b00001);
    @(negedge clk);
    chk("sim pre wi", {30'd0, write_index}, 32'd1);
    pulse(5'b10111);
    chk("sim +1 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);
    @(negedge clk);
    chk("sim +2 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);
    chk("sim +2 fv", {31'd0, frame_valid}, 32'd1);
    @(negedge clk);
    chk("sim +3 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'b001);
    chk("sim +3 err", {31'd0, save_err}, 32'd0);
    chk("sim +3 si", {30'd0, save_index}, 32'd1);
    chk("sim +3 sbase", {8'd0, save_base}, 32'h100000);
    @(negedge clk);
    chk("sim +4 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'b010);
    chk("sim +4 ri", {30'd0, read_index}, 32'd1);
    @(negedge clk);
    chk("sim +5 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'b100);
    chk("sim +5 wi", {30'd0, write_index}, 32'd2);
    chk("sim +5 wbase", {8'd0, write_base}, 32'h200000);
    @(negedge clk);
    chk("sim +6 acks", {29'd0, wr_frame_ack, rd_frame_ack, save_ack}, 32'd0);

    // Drop counter saturation: first done drops nothing, later ones all drop.
    do_reset();
    for (int n = 0; n < 255; n++) pulse(5'b10000);
    @(negedge clk);
    chk("drop after 255", {24'd0, drop_cnt}, 32'd254);
    for (int n = 0; n < 45; n++) pulse(5'b10000);
    @(negedge clk);
    chk("drop after 300", {24'd0, drop_cnt}, 32'd255);
    chk("drop fv", {31'd0, frame_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
